// File: rtl/response_reorder_buffer_pkg.sv
// Shared widths and types for the response reorder buffer.
// Defining RESP_REORDER_BYPASS_EN lets an in-order response skip storage.
package response_reorder_buffer_pkg;

  localparam int DATA_WIDTH         = 8;
  localparam int ID_WIDTH           = 3;
  localparam int RESP_REORDER_DEPTH = 1 << ID_WIDTH;

  // What the output register does on the coming edge.
  typedef enum logic [1:0] {
    OUT_IDLE        = 2'd0,
    OUT_HOLD        = 2'd1,
    OUT_LOAD_STORE  = 2'd2,
    OUT_LOAD_BYPASS = 2'd3
  } out_action_e;

endpackage

// File: rtl/response_reorder_buffer_if.sv
// Response bus between shared_resource, the reorder buffer and the consumer.
// Optional feature macro: RESP_REORDER_BYPASS_EN (affects the block, not this bus).
interface response_reorder_buffer_if
  import response_reorder_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int ID_W   = ID_WIDTH
) ();

  // Upstream: in_valid marks a response for one cycle and is never stalled.
  // Downstream: a transfer happens on an edge where out_valid & !in_stall;
  // while out_valid & in_stall, out_data/out_id/out_valid are held stable.
  logic [DATA_W-1:0] in_data;
  logic [ID_W-1:0]   in_id;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic [ID_W-1:0]   out_id;
  logic              out_valid;
  logic              in_stall;
  logic              out_overflow;
  logic [ID_W:0]     out_count;

  modport slave (
    input  in_data, in_id, in_valid, in_stall,
    output out_data, out_id, out_valid, out_overflow, out_count
  );

  modport master (
    output in_data, in_id, in_valid, in_stall,
    input  out_data, out_id, out_valid, out_overflow, out_count
  );

endinterface

// File: rtl/response_reorder_buffer_storage.sv
// Reorder storage: DEPTH x DATA_W data array plus per-entry valid bits.
// One write port, one read port with clear-on-read; write wins on the same index.
module reorder_storage
  import response_reorder_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int ID_W   = ID_WIDTH,
  parameter int DEPTH  = 1 << ID_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ID_W-1:0]   wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_en_i,
  input  logic [ID_W-1:0]   rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [DEPTH-1:0]  valid_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear first so a refill of the entry being released on this edge survives.
  always_comb begin
    valid_d = valid_q;
    if (clr_en_i) valid_d[rd_idx_i] = 1'b0;
    if (wr_en_i)  valid_d[wr_idx_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign valid_o   = valid_q;

endmodule

// File: rtl/response_reorder_buffer.sv
// Stores out-of-order responses by ID and releases them in ascending ID order.
// Optional feature macro: RESP_REORDER_BYPASS_EN (direct load of the expected ID).
module response_reorder_buffer
  import response_reorder_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int ID_W   = ID_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  response_reorder_buffer_if.slave   bus
);

  localparam int DEPTH = 1 << ID_W;

  logic [ID_W-1:0]   expect_q, expect_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;
  logic [ID_W:0]     count_q, count_d;

  logic [DEPTH-1:0]  entry_valid;
  logic [DATA_W-1:0] rd_data;
  logic              out_free;
  logic              release_go;
  logic              bypass_go;
  logic              occupied;
  logic              wr_en;
  out_action_e       out_action;

  reorder_storage #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .DEPTH  (DEPTH)
  ) u_storage (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_idx_i  (bus.in_id),
    .wr_data_i (bus.in_data),
    .clr_en_i  (release_go),
    .rd_idx_i  (expect_q),
    .rd_data_o (rd_data),
    .valid_o   (entry_valid)
  );

  assign out_free   = !out_valid_q || !bus.in_stall;
  assign release_go = entry_valid[expect_q] && out_free;

  // The entry being released on this edge is free for a new write.
  assign occupied = entry_valid[bus.in_id] &&
                    !(release_go && (bus.in_id == expect_q));

`ifdef RESP_REORDER_BYPASS_EN
  assign bypass_go = bus.in_valid && (bus.in_id == expect_q) &&
                     !entry_valid[expect_q] && out_free;
`else
  assign bypass_go = 1'b0;
`endif

  assign wr_en = bus.in_valid && !occupied && !bypass_go;

  always_comb begin
    out_action = OUT_HOLD;
    if (release_go)     out_action = OUT_LOAD_STORE;
    else if (bypass_go) out_action = OUT_LOAD_BYPASS;
    else if (out_free)  out_action = OUT_IDLE;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    case (out_action)
      OUT_LOAD_STORE: begin
        out_data_d  = rd_data;
        out_id_d    = expect_q;
        out_valid_d = 1'b1;
      end
      OUT_LOAD_BYPASS: begin
        out_data_d  = bus.in_data;
        out_id_d    = expect_q;
        out_valid_d = 1'b1;
      end
      OUT_IDLE: out_valid_d = 1'b0;
      default:  ;
    endcase
  end

  always_comb begin
    expect_d   = expect_q + ID_W'(release_go || bypass_go);
    overflow_d = overflow_q || (bus.in_valid && occupied);
    count_d    = count_q + {{ID_W{1'b0}}, wr_en} - {{ID_W{1'b0}}, release_go};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expect_q    <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      expect_q    <= expect_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
    end
  end

  assign bus.out_data     = out_data_q;
  assign bus.out_id       = out_id_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_overflow = overflow_q;
  assign bus.out_count    = count_q;

endmodule

// File: tb/tb_response_reorder_buffer.sv
// Directed bench for response_reorder_buffer (default build, bypass disabled).
module tb_response_reorder_buffer;
  import response_reorder_buffer_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  response_reorder_buffer_if #(.DATA_W(DATA_WIDTH), .ID_W(ID_WIDTH)) bus ();

  response_reorder_buffer #(.DATA_W(DATA_WIDTH), .ID_W(ID_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // v=0 checks only valid and count; data/id are don't-care then.
  task automatic eo(input string tag, input bit v, input int id, input int data, input int cnt);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    if (v) begin
      chk({tag, "_id"},   32'(bus.out_id),   32'(id));
      chk({tag, "_data"}, 32'(bus.out_data), 32'(data));
    end
    chk({tag, "_count"}, 32'(bus.out_count), 32'(cnt));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input int data);
    bus.in_valid = 1'b1;
    bus.in_id    = ID_WIDTH'(id);
    bus.in_data  = DATA_WIDTH'(data);
    tick();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_stall = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_id    = '0;
    bus.in_data  = '0;
    bus.in_stall = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_id",    32'(bus.out_id),    32'd0);
    chk("rst_data",  32'(bus.out_data),  32'd0);
    chk("rst_count", 32'(bus.out_count), 32'd0);
    chk("rst_ovf",   32'(bus.out_overflow), 32'd0);
    reset = 1'b1;

    // in-order: first output two edges after ID 0 is written
    send(0, 'h10); eo("io_e1", 0, 0, 0, 1);
    send(1, 'h11); eo("io_e2", 1, 0, 'h10, 1);
    send(2, 'h12); eo("io_e3", 1, 1, 'h11, 1);
    send(3, 'h13); eo("io_e4", 1, 2, 'h12, 1);
    idle();        eo("io_e5", 1, 3, 'h13, 0);
    idle();        eo("io_e6", 0, 0, 0, 0);

    // reorder: IDs 2,0,3,1
    do_reset();
    send(2, 'hA2); eo("ro_e1", 0, 0, 0, 1);
    send(0, 'hA0); eo("ro_e2", 0, 0, 0, 2);
    send(3, 'hA3); eo("ro_e3", 1, 0, 'hA0, 2);
    send(1, 'hA1); eo("ro_e4", 0, 0, 0, 3);
    idle();        eo("ro_e5", 1, 1, 'hA1, 2);
    idle();        eo("ro_e6", 1, 2, 'hA2, 1);
    idle();        eo("ro_e7", 1, 3, 'hA3, 0);
    idle();        eo("ro_e8", 0, 0, 0, 0);

    // backpressure: five stalled edges with out_valid high
    do_reset();
    send(0, 'h30); eo("bp_e1", 0, 0, 0, 1);
    send(1, 'h31); eo("bp_e2", 1, 0, 'h30, 1);
    bus.in_stall = 1'b1;
    send(2, 'h32); eo("bp_s1", 1, 0, 'h30, 2);
    send(3, 'h33); eo("bp_s2", 1, 0, 'h30, 3);
    idle();        eo("bp_s3", 1, 0, 'h30, 3);
    idle();        eo("bp_s4", 1, 0, 'h30, 3);
    idle();        eo("bp_s5", 1, 0, 'h30, 3);
    bus.in_stall = 1'b0;
    idle();        eo("bp_r1", 1, 1, 'h31, 2);
    idle();        eo("bp_r2", 1, 2, 'h32, 1);
    idle();        eo("bp_r3", 1, 3, 'h33, 0);
    idle();        eo("bp_r4", 0, 0, 0, 0);

    // overflow: ID 5 twice, first payload kept
    do_reset();
    send(5, 'h55); eo("ov_e1", 0, 0, 0, 1);
    chk("ov_flag_e1", 32'(bus.out_overflow), 32'd0);
    send(5, 'h66); eo("ov_e2", 0, 0, 0, 1);
    chk("ov_flag_e2", 32'(bus.out_overflow), 32'd1);
    send(0, 'h50); eo("ov_e3", 0, 0, 0, 2);
    send(1, 'h51); eo("ov_e4", 1, 0, 'h50, 2);
    send(2, 'h52); eo("ov_e5", 1, 1, 'h51, 2);
    send(3, 'h53); eo("ov_e6", 1, 2, 'h52, 2);
    send(4, 'h54); eo("ov_e7", 1, 3, 'h53, 2);
    idle();        eo("ov_e8", 1, 4, 'h54, 1);
    idle();        eo("ov_e9", 1, 5, 'h55, 0);
    idle();        eo("ov_e10", 0, 0, 0, 0);
    chk("ov_flag_sticky", 32'(bus.out_overflow), 32'd1);

    // wrap: 2*DEPTH sequential IDs
    do_reset();
    send(0, 'h80); eo("wr_e1", 0, 0, 0, 1);
    for (int i = 1; i < 2 * RESP_REORDER_DEPTH; i++) begin
      send(i % RESP_REORDER_DEPTH, 'h80 + i);
      eo("wr_str", 1, (i - 1) % RESP_REORDER_DEPTH, 'h80 + i - 1, 1);
    end
    idle(); eo("wr_last", 1, RESP_REORDER_DEPTH - 1, 'h8F, 0);
    idle(); eo("wr_drain", 0, 0, 0, 0);

    // write to entry 0 on its own release edge is accepted
    send(0, 'hC0); eo("rf_e1", 0, 0, 0, 1);
    send(0, 'hC1); eo("rf_e2", 1, 0, 'hC0, 1);
    chk("rf_no_ovf", 32'(bus.out_overflow), 32'd0);
    idle();        eo("rf_gap", 0, 0, 0, 1);
    for (int j = 1; j < RESP_REORDER_DEPTH; j++) begin
      send(j, 'hD0 + j);
      if (j == 1) eo("rf_fill1", 0, 0, 0, 2);
      else        eo("rf_fill", 1, j - 1, 'hD0 + j - 1, 2);
    end
    idle(); eo("rf_id7", 1, 7, 'hD7, 1);
    idle(); eo("rf_wrap0", 1, 0, 'hC1, 0);
    idle(); eo("rf_end", 0, 0, 0, 0);

    // reset mid-run with 3 entries held
    do_reset();
    send(1, 'hE1);
    send(2, 'hE2);
    send(3, 'hE3);
    send(3, 'hEE);
    send(0, 'hE0); eo("mr_e5", 0, 0, 0, 4);
    chk("mr_ovf_set", 32'(bus.out_overflow), 32'd1);
    idle();        eo("mr_e6", 1, 0, 'hE0, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_async_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_async_count", 32'(bus.out_count), 32'd0);
    chk("mr_async_ovf",   32'(bus.out_overflow), 32'd0);
    chk("mr_async_id",    32'(bus.out_id), 32'd0);
    chk("mr_async_data",  32'(bus.out_data), 32'd0);
    reset = 1'b1;
    send(0, 'hF0); eo("mr_r1", 0, 0, 0, 1);
    idle();        eo("mr_r2", 1, 0, 'hF0, 0);
    idle();        eo("mr_r3", 0, 0, 0, 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
